vga_rx_480p: RTL

- Receiving end of the 640x480 VGA interface driven by the pixel-generation tops.
- Samples hsync/vsync/de/RGB in the pixel clock domain and recovers screen coordinates from the sync edges alone.
- Verifies line/frame timing, reports lock, and re-emits a registered, coordinate-tagged pixel stream for checkers or a frame capture sink.

---
 rtl/vga_rx_pkg.sv | 21 ++
 rtl/sync_period_meter.sv | 45 ++++
 rtl/vga_rx_480p.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA receiver.
// Holds the receiver lock-state enum and the default 640x480 timing, which the
// display timing generator uses as well so both ends agree on one set of numbers.
package vga_rx_pkg;

  localparam int DEF_CORDW      = 10;
  localparam int DEF_H_RES      = 640;
  localparam int DEF_V_RES      = 480;
  localparam int DEF_H_SYNC_STA = 656;
  localparam int DEF_H_TOTAL    = 800;
  localparam int DEF_V_SYNC_STA = 490;
  localparam int DEF_V_TOTAL    = 525;
  localparam int DEF_LOCK_LINES = 4;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    H_LOCKED = 2'd1,
    LOCKED   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_period_meter.sv
// Falling-edge detector plus saturating period counter for an active-low sync.
// Counts cnt_en events between consecutive falls; match is only meaningful in
// the cycle where fall is high and says the period just closed equals target.
//   clk_pix, rst_pix : clock, synchronous active-high reset
//   sync_n           : raw active-low sync input (current sample)
//   cnt_en           : event to count (every clock, or line events)
//   target           : expected period
//   fall             : sync fell on the current sample
//   match            : closed period == target
module sync_period_meter #(
  parameter int CORDW = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             sync_n,
  input  logic             cnt_en,
  input  logic [CORDW-1:0] target,
  output logic             fall,
  output logic             match
);

  localparam logic [CORDW:0] CNT_MAX = '1;

  logic           prev;
  logic [CORDW:0] cnt;

  assign fall  = prev & ~sync_n;
  // Extra MSB must be clear: a saturated counter can never alias onto target.
  assign match = (cnt == {1'b0, target});

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      prev <= 1'b1;
      cnt  <= '0;
    end else begin
      prev <= sync_n;
      // The fall cycle itself is the first event of the new period.
      if (fall)
        cnt <= {{CORDW{1'b0}}, cnt_en};
      else if (cnt_en && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_rx_480p.sv
// VGA receiver: recovers sx/sy from sync edges, verifies line and frame timing,
// reports lock and re-emits a registered, coordinate-tagged pixel stream.
//   clk_pix, rst_pix          : pixel clock, synchronous active-high reset
//   vga_hsync/vsync           : active-low syncs
//   vga_de, vga_r/g/b         : source data enable and colour
//   rx_sx/rx_sy               : coordinate of the previous cycle's sample
//   rx_de, rx_r/g/b           : that sample's recovered de (lock-gated) and colour
//   frame_start               : pulse at (0,0) while locked
//   locked                    : LOCKED state
//   de_err                    : source de disagreed with recovered de while locked
//   err_count                 : saturating count of cycles with any error
module vga_rx_480p
  import vga_rx_pkg::*;
#(
  parameter int CORDW      = DEF_CORDW,
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int H_SYNC_STA = DEF_H_SYNC_STA,
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int V_SYNC_STA = DEF_V_SYNC_STA,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic             vga_de,
  input  logic [3:0]       vga_r,
  input  logic [3:0]       vga_g,
  input  logic [3:0]       vga_b,
  output logic [CORDW-1:0] rx_sx,
  output logic [CORDW-1:0] rx_sy,
  output logic             rx_de,
  output logic [3:0]       rx_r,
  output logic [3:0]       rx_g,
  output logic [3:0]       rx_b,
  output logic             frame_start,
  output logic             locked,
  output logic             de_err,
  output logic [7:0]       err_count
);

  localparam logic [CORDW-1:0] HR    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] VR    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HSS   = CORDW'(H_SYNC_STA);
  localparam logic [CORDW-1:0] VSS   = CORDW'(V_SYNC_STA);
  localparam logic [CORDW-1:0] HT    = CORDW'(H_TOTAL);
  localparam logic [CORDW-1:0] VT    = CORDW'(V_TOTAL);
  localparam logic [CORDW-1:0] HT_M1 = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VT_M1 = CORDW'(V_TOTAL - 1);
  localparam int               GLW   = $clog2(LOCK_LINES + 1);
  localparam logic [GLW-1:0]   LOCK_N = GLW'(LOCK_LINES);

  rx_state_t        state, state_nxt;
  logic [CORDW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [GLW-1:0]   good_lines;
  logic             first_h, first_v;
  logic             h_fall, h_match, v_fall, v_match;
  logic             line_bad, frame_chk, frame_good, frame_bad;
  logic             exp_de, is_locked, de_bad, err_any;

  // Line meter counts clocks; frame meter counts hsync falls.
  sync_period_meter #(.CORDW(CORDW)) u_h_meter (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .sync_n  (vga_hsync),
    .cnt_en  (1'b1),
    .target  (HT),
    .fall    (h_fall),
    .match   (h_match)
  );

  sync_period_meter #(.CORDW(CORDW)) u_v_meter (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .sync_n  (vga_vsync),
    .cnt_en  (h_fall),
    .target  (VT),
    .fall    (v_fall),
    .match   (v_match)
  );

  // h_nxt/v_nxt is the coordinate of the sample on the inputs this cycle;
  // the counter registers therefore hold the previous sample's coordinate.
  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_fall) begin
      h_nxt = HSS;
    end else if (h_cnt == HT_M1) begin
      h_nxt = '0;
      v_nxt = (v_cnt == VT_M1) ? '0 : v_cnt + 1'b1;
    end
    if (v_fall)
      v_nxt = VSS;
  end

  assign is_locked  = (state == LOCKED);
  assign line_bad   = h_fall & first_h & ~h_match;
  assign frame_chk  = v_fall & first_v & (state != SEARCH);
  assign frame_good = frame_chk & v_match;
  assign frame_bad  = frame_chk & ~v_match;
  assign exp_de     = (h_nxt < HR) && (v_nxt < VR);
  assign de_bad     = is_locked && (vga_de != exp_de);
  assign err_any    = line_bad | frame_bad | de_bad;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= SEARCH;
    else         state <= state_nxt;
  end

  // A bad line period drops out of any lock level, not just full lock.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:   if (!line_bad && good_lines == LOCK_N) state_nxt = H_LOCKED;
      H_LOCKED: if (line_bad)        state_nxt = SEARCH;
                else if (frame_good) state_nxt = LOCKED;
      LOCKED:   if (line_bad)        state_nxt = SEARCH;
                else if (frame_bad)  state_nxt = H_LOCKED;
      default:  state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      good_lines  <= '0;
      first_h     <= 1'b0;
      first_v     <= 1'b0;
      rx_de       <= 1'b0;
      rx_r        <= '0;
      rx_g        <= '0;
      rx_b        <= '0;
      frame_start <= 1'b0;
      de_err      <= 1'b0;
      err_count   <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (h_fall) begin
        first_h <= 1'b1;
        if (first_h) begin
          if (!h_match)                good_lines <= '0;
          else if (good_lines != LOCK_N) good_lines <= good_lines + 1'b1;
        end
      end
      // Frame count only becomes trustworthy once line timing is locked.
      first_v     <= (state == SEARCH) ? 1'b0 : (first_v | v_fall);
      rx_de       <= is_locked & exp_de;
      rx_r        <= vga_r;
      rx_g        <= vga_g;
      rx_b        <= vga_b;
      frame_start <= is_locked && h_nxt == '0 && v_nxt == '0;
      de_err      <= de_bad;
      if (err_any && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

  assign rx_sx  = h_cnt;
  assign rx_sy  = v_cnt;
  assign locked = is_locked;

endmodule
